axi4l_mem_bridge: RTL and testbench

- Parametrised AXI4-Lite slave to native valid/ready memory master bridge with programmable address-remap windows.
- Generalises the single fixed 0x30→0x00 top-byte remap to NUM_REMAP windows.
- Adds read/write arbitration, independent AW/W capture and an optional bus-timeout error response.
- Sits between an AXI4-Lite core (e.g. minirv) and the SoC native memory bus inside the core wrapper.

---
 rtl/axi4l_mem_bridge.sv | 188 ++++++++++++++++++
 tb/tb_axi4l_mem_bridge.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4l_mem_bridge.sv
// rtl/axi4l_mem_bridge.sv - AXI4-Lite slave to native valid/ready memory master bridge
// Remap windows, read/write arbitration, independent AW/W/AR capture, optional bus timeout.
module axi4l_mem_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REMAP = 2,
  parameter int MATCH_BITS = 8,
  parameter logic [NUM_REMAP*MATCH_BITS-1:0] REMAP_FROM = {8'h30, 8'h40},
  parameter logic [NUM_REMAP*MATCH_BITS-1:0] REMAP_TO = {8'h00, 8'h10},
  parameter logic [NUM_REMAP-1:0] REMAP_EN = 2'b11,
  parameter int ARB_MODE = 0,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr_i,
  input  logic                    s_awvalid_i,
  output logic                    s_awready_o,
  input  logic [DATA_WIDTH-1:0]   s_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb_i,
  input  logic                    s_wvalid_i,
  output logic                    s_wready_o,
  output logic [1:0]              s_bresp_o,
  output logic                    s_bvalid_o,
  input  logic                    s_bready_i,
  input  logic [ADDR_WIDTH-1:0]   s_araddr_i,
  input  logic                    s_arvalid_i,
  output logic                    s_arready_o,
  output logic [DATA_WIDTH-1:0]   s_rdata_o,
  output logic [1:0]              s_rresp_o,
  output logic                    s_rvalid_o,
  input  logic                    s_rready_i,
  output logic                    mem_valid_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  input  logic                    mem_ready_i,
  output logic [7:0]              timeout_cnt_o
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [31:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, WR_REQ, RD_REQ, B_RESP, R_RESP} state_e;

  state_e                  state_q, state_d;
  logic [31:0]             cnt_q, cnt_d;
  logic                    rr_wr_last_q, rr_wr_last_d;
  logic                    aw_full_q, w_full_q, ar_full_q;
  logic [ADDR_WIDTH-1:0]   aw_addr_q, ar_addr_q;
  logic [DATA_WIDTH-1:0]   w_data_q, rdata_q;
  logic [STRB_W-1:0]       w_strb_q;
  logic [1:0]              bresp_q, rresp_q;
  logic [7:0]              tcnt_q;

  logic                    wr_pend, in_req, timed_out, req_done;
  logic [ADDR_WIDTH-1:0]   req_addr;

  // Lowest-index enabled window whose MSBs match wins; low bits never change.
  function automatic logic [ADDR_WIDTH-1:0] remap(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] r;
    logic                  hit;
    r   = a;
    hit = 1'b0;
    for (int i = 0; i < NUM_REMAP; i++) begin
      if (!hit && REMAP_EN[i] &&
          a[ADDR_WIDTH-1 -: MATCH_BITS] == REMAP_FROM[i*MATCH_BITS +: MATCH_BITS]) begin
        r[ADDR_WIDTH-1 -: MATCH_BITS] = REMAP_TO[i*MATCH_BITS +: MATCH_BITS];
        hit = 1'b1;
      end
    end
    return r;
  endfunction

  assign wr_pend   = aw_full_q & w_full_q;
  assign in_req    = (state_q == WR_REQ) || (state_q == RD_REQ);
  assign timed_out = (TIMEOUT_CYCLES > 0) && (cnt_q == TO_LAST) && !mem_ready_i;
  assign req_done  = in_req && (mem_ready_i || timed_out);
  assign req_addr  = (state_q == WR_REQ) ? aw_addr_q : ar_addr_q;

  assign s_awready_o   = ~aw_full_q & ~rst_i;
  assign s_wready_o    = ~w_full_q & ~rst_i;
  assign s_arready_o   = ~ar_full_q & ~rst_i;
  assign s_bvalid_o    = (state_q == B_RESP);
  assign s_rvalid_o    = (state_q == R_RESP);
  assign s_bresp_o     = bresp_q;
  assign s_rresp_o     = rresp_q;
  assign s_rdata_o     = rdata_q;
  assign mem_valid_o   = in_req;
  assign mem_addr_o    = in_req ? remap(req_addr) : '0;
  assign mem_wdata_o   = (state_q == WR_REQ) ? w_data_q : '0;
  assign mem_wstrb_o   = (state_q == WR_REQ) ? w_strb_q : '0;
  assign timeout_cnt_o = tcnt_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rr_wr_last_d = rr_wr_last_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Round-robin memory only advances on contested decisions.
        if (wr_pend && ar_full_q) begin
          if (ARB_MODE == 0 || !rr_wr_last_q) begin
            state_d      = WR_REQ;
            rr_wr_last_d = 1'b1;
          end else begin
            state_d      = RD_REQ;
            rr_wr_last_d = 1'b0;
          end
        end else if (wr_pend) begin
          state_d = WR_REQ;
        end else if (ar_full_q) begin
          state_d = RD_REQ;
        end
      end
      WR_REQ, RD_REQ: begin
        if (req_done) begin
          state_d = (state_q == WR_REQ) ? B_RESP : R_RESP;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      B_RESP: if (s_bready_i) state_d = IDLE;
      R_RESP: if (s_rready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rr_wr_last_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rr_wr_last_q <= rr_wr_last_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      ar_full_q <= 1'b0;
      aw_addr_q <= '0;
      ar_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= '0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      tcnt_q    <= '0;
    end else begin
      if (s_awvalid_i && s_awready_o) begin
        aw_full_q <= 1'b1;
        aw_addr_q <= s_awaddr_i;
      end
      if (s_wvalid_i && s_wready_o) begin
        w_full_q <= 1'b1;
        w_data_q <= s_wdata_i;
        w_strb_q <= s_wstrb_i;
      end
      if (s_arvalid_i && s_arready_o) begin
        ar_full_q <= 1'b1;
        ar_addr_q <= s_araddr_i;
      end
      // Holding flags are full while their request is in flight, so no capture collides here.
      if (req_done) begin
        if (state_q == WR_REQ) begin
          aw_full_q <= 1'b0;
          w_full_q  <= 1'b0;
          bresp_q   <= mem_ready_i ? RESP_OKAY : RESP_SLVERR;
        end else begin
          ar_full_q <= 1'b0;
          rresp_q   <= mem_ready_i ? RESP_OKAY : RESP_SLVERR;
          rdata_q   <= mem_ready_i ? mem_rdata_i : '0;
        end
        if (!mem_ready_i && tcnt_q != 8'hFF) tcnt_q <= tcnt_q + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_axi4l_mem_bridge.sv
// tb/tb_axi4l_mem_bridge.sv - scoreboard bench for axi4l_mem_bridge
// Instance 0: write priority, no timeout. Instance 1: round-robin, TIMEOUT_CYCLES=4.
module tb_axi4l_mem_bridge;

  typedef struct packed {logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb;} mem_req_t;
  typedef struct packed {logic is_wr; logic [1:0] resp; logic [31:0] data;} rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0][31:0] awaddr, wdata, araddr, mem_rdata;
  logic [1:0][3:0]  wstrb;
  logic [1:0]       awvalid, wvalid, arvalid, bready, rready, mem_ready;
  wire  [1:0]       awready, wready, arready, bvalid, rvalid, mem_valid;
  wire  [1:0][1:0]  bresp, rresp;
  wire  [1:0][31:0] rdata, mem_addr, mem_wdata;
  wire  [1:0][3:0]  mem_wstrb;
  wire  [1:0][7:0]  timeout_cnt;

  int vectors = 0;
  int miscompares = 0;
  mem_req_t mem_exp_q[$];
  rsp_t     rsp_exp_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axi4l_mem_bridge #(.ARB_MODE(g), .TIMEOUT_CYCLES(g * 4)) u_dut (
      .clk_i(clk), .rst_i(rst),
      .s_awaddr_i(awaddr[g]), .s_awvalid_i(awvalid[g]), .s_awready_o(awready[g]),
      .s_wdata_i(wdata[g]), .s_wstrb_i(wstrb[g]), .s_wvalid_i(wvalid[g]), .s_wready_o(wready[g]),
      .s_bresp_o(bresp[g]), .s_bvalid_o(bvalid[g]), .s_bready_i(bready[g]),
      .s_araddr_i(araddr[g]), .s_arvalid_i(arvalid[g]), .s_arready_o(arready[g]),
      .s_rdata_o(rdata[g]), .s_rresp_o(rresp[g]), .s_rvalid_o(rvalid[g]), .s_rready_i(rready[g]),
      .mem_valid_o(mem_valid[g]), .mem_addr_o(mem_addr[g]), .mem_wdata_o(mem_wdata[g]),
      .mem_wstrb_o(mem_wstrb[g]), .mem_rdata_i(mem_rdata[g]), .mem_ready_i(mem_ready[g]),
      .timeout_cnt_o(timeout_cnt[g])
    );
  end

  function automatic logic [117:0] snap(input logic s);
    return {awready[s], wready[s], arready[s], bvalid[s], rvalid[s], mem_valid[s],
            bresp[s], rresp[s], rdata[s], mem_addr[s], mem_wdata[s], mem_wstrb[s], timeout_cnt[s]};
  endfunction

  // Raises the selected valids together and drops each one after its own handshake.
  task automatic send(input logic s, input bit da, input bit dw, input bit dr,
                      input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                      input logic [31:0] ra);
    bit ha, hw, hr;
    awaddr[s] = wa; wdata[s] = wd; wstrb[s] = ws; araddr[s] = ra;
    awvalid[s] = da; wvalid[s] = dw; arvalid[s] = dr;
    for (int n = 0; n < 50 && (awvalid[s] || wvalid[s] || arvalid[s]); n++) begin
      ha = awvalid[s] & awready[s];
      hw = wvalid[s] & wready[s];
      hr = arvalid[s] & arready[s];
      @(negedge clk);
      if (ha) awvalid[s] = 1'b0;
      if (hw) wvalid[s] = 1'b0;
      if (hr) arvalid[s] = 1'b0;
    end
    awvalid[s] = 1'b0; wvalid[s] = 1'b0; arvalid[s] = 1'b0;
  endtask

  task automatic mem_serve(input logic s, input int lat, input logic [31:0] rd,
                           output mem_req_t q, output bit ok);
    ok = 1'b0;
    q  = '0;
    for (int n = 0; n < 50; n++) begin
      if (mem_valid[s]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) return;
    repeat (lat) @(negedge clk);
    q = {mem_addr[s], mem_wdata[s], mem_wstrb[s]};
    mem_ready[s] = 1'b1; mem_rdata[s] = rd;
    @(negedge clk);
    mem_ready[s] = 1'b0; mem_rdata[s] = '0;
  endtask

  task automatic wait_rsp(input logic s, input int hold, output rsp_t r, output bit ok);
    ok = 1'b0;
    r  = '0;
    for (int n = 0; n < 50; n++) begin
      if (bvalid[s] || rvalid[s]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) return;
    repeat (hold) @(negedge clk);
    if (bvalid[s]) r = {1'b1, bresp[s], 32'h0};
    else           r = {1'b0, rresp[s], rdata[s]};
    bready[s] = 1'b1; rready[s] = 1'b1;
    @(negedge clk);
    bready[s] = 1'b0; rready[s] = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (snap(i[0]) !== 118'h0) begin
        miscompares++;
        $display("FAIL reset_held[%0d]: got %h, expected 0", i, snap(i[0]));
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (snap(i[0]) !== {3'b111, 115'h0}) begin
        miscompares++;
        $display("FAIL reset_released[%0d]: got %h, expected %h", i, snap(i[0]), {3'b111, 115'h0});
      end
    end
  endtask

  task automatic test_read_remap();
    mem_req_t gm, em;
    rsp_t gr, er;
    bit ok;
    mem_exp_q.push_back({32'h0000_0010, 32'h0, 4'h0});
    rsp_exp_q.push_back({1'b0, 2'b00, 32'hDEAD_BEEF});
    send(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h3000_0010);
    mem_serve(1'b0, 2, 32'hDEAD_BEEF, gm, ok);
    em = mem_exp_q.pop_front();
    vectors++;
    if ({ok, gm} !== {1'b1, em}) begin
      miscompares++;
      $display("FAIL read_mem_req: got ok=%0b %h, expected %h", ok, gm, em);
    end
    wait_rsp(1'b0, 0, gr, ok);
    er = rsp_exp_q.pop_front();
    vectors++;
    if ({ok, gr} !== {1'b1, er}) begin
      miscompares++;
      $display("FAIL read_rsp: got ok=%0b %h, expected %h", ok, gr, er);
    end
  endtask

  task automatic test_write_w_first();
    mem_req_t gm, em;
    rsp_t gr, er;
    bit ok, early, extra;
    mem_exp_q.push_back({32'h1000_0004, 32'h1234_5678, 4'b0011});
    rsp_exp_q.push_back({1'b1, 2'b00, 32'h0});
    send(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h1234_5678, 4'b0011, 32'h0);
    early = 1'b0;
    repeat (2) begin
      if (mem_valid[0] || wready[0]) early = 1'b1;
      @(negedge clk);
    end
    vectors++;
    if (early !== 1'b0) begin
      miscompares++;
      $display("FAIL w_only_wait: got early=%0b, expected 0", early);
    end
    send(1'b0, 1'b1, 1'b0, 1'b0, 32'h4000_0004, 32'h0, 4'h0, 32'h0);
    mem_serve(1'b0, 0, 32'h0, gm, ok);
    em = mem_exp_q.pop_front();
    vectors++;
    if ({ok, gm} !== {1'b1, em}) begin
      miscompares++;
      $display("FAIL write_mem_req: got ok=%0b %h, expected %h", ok, gm, em);
    end
    wait_rsp(1'b0, 0, gr, ok);
    er = rsp_exp_q.pop_front();
    vectors++;
    if ({ok, gr} !== {1'b1, er}) begin
      miscompares++;
      $display("FAIL write_rsp: got ok=%0b %h, expected %h", ok, gr, er);
    end
    extra = 1'b0;
    repeat (5) begin
      if (mem_valid[0] || bvalid[0]) extra = 1'b1;
      @(negedge clk);
    end
    vectors++;
    if (extra !== 1'b0) begin
      miscompares++;
      $display("FAIL write_single: got extra activity=%0b, expected 0", extra);
    end
  endtask

  task automatic test_arbitration(input logic s, input bit rd_first, input logic [7:0] tag);
    mem_req_t gm, em;
    rsp_t gr, er;
    bit ok;
    mem_req_t wm, rm;
    rsp_t wr, rr;
    wm = {8'h00, 16'h0, tag, {4{tag}}, 4'hF};
    rm = {8'h10, 16'h0, tag, 32'h0, 4'h0};
    wr = {1'b1, 2'b00, 32'h0};
    rr = {1'b0, 2'b00, ~{4{tag}}};
    if (rd_first) begin
      mem_exp_q.push_back(rm); rsp_exp_q.push_back(rr);
      mem_exp_q.push_back(wm); rsp_exp_q.push_back(wr);
    end else begin
      mem_exp_q.push_back(wm); rsp_exp_q.push_back(wr);
      mem_exp_q.push_back(rm); rsp_exp_q.push_back(rr);
    end
    send(s, 1'b1, 1'b1, 1'b1, {8'h30, 16'h0, tag}, {4{tag}}, 4'hF, {8'h40, 16'h0, tag});
    for (int k = 0; k < 2; k++) begin
      mem_serve(s, 0, ~{4{tag}}, gm, ok);
      em = mem_exp_q.pop_front();
      vectors++;
      if ({ok, gm} !== {1'b1, em}) begin
        miscompares++;
        $display("FAIL arb%0d_mem[%0d]: got ok=%0b %h, expected %h", s, k, ok, gm, em);
      end
      wait_rsp(s, 0, gr, ok);
      er = rsp_exp_q.pop_front();
      vectors++;
      if ({ok, gr} !== {1'b1, er}) begin
        miscompares++;
        $display("FAIL arb%0d_rsp[%0d]: got ok=%0b %h, expected %h", s, k, ok, gr, er);
      end
    end
  endtask

  task automatic test_timeout();
    mem_req_t gm, em;
    rsp_t gr, er;
    bit ok;
    int hi;
    rsp_exp_q.push_back({1'b0, 2'b10, 32'h0});
    send(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h3000_0020);
    for (int n = 0; n < 50 && !mem_valid[1]; n++) @(negedge clk);
    hi = 0;
    while (mem_valid[1] && hi < 20) begin
      hi++;
      @(negedge clk);
    end
    vectors++;
    if (hi !== 4) begin
      miscompares++;
      $display("FAIL timeout_valid_cycles: got %0d, expected 4", hi);
    end
    wait_rsp(1'b1, 0, gr, ok);
    er = rsp_exp_q.pop_front();
    vectors++;
    if ({ok, gr} !== {1'b1, er}) begin
      miscompares++;
      $display("FAIL timeout_rsp: got ok=%0b %h, expected %h", ok, gr, er);
    end
    vectors++;
    if (timeout_cnt[1] !== 8'd1) begin
      miscompares++;
      $display("FAIL timeout_cnt_after_abort: got %0d, expected 1", timeout_cnt[1]);
    end
    mem_exp_q.push_back({32'h0000_0024, 32'h0, 4'h0});
    rsp_exp_q.push_back({1'b0, 2'b00, 32'hCAFE_F00D});
    send(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h3000_0024);
    mem_serve(1'b1, 3, 32'hCAFE_F00D, gm, ok);
    em = mem_exp_q.pop_front();
    vectors++;
    if ({ok, gm} !== {1'b1, em}) begin
      miscompares++;
      $display("FAIL late_ready_mem: got ok=%0b %h, expected %h", ok, gm, em);
    end
    wait_rsp(1'b1, 0, gr, ok);
    er = rsp_exp_q.pop_front();
    vectors++;
    if ({ok, gr, timeout_cnt[1]} !== {1'b1, er, 8'd1}) begin
      miscompares++;
      $display("FAIL late_ready_rsp: got ok=%0b %h cnt=%0d, expected %h cnt=1", ok, gr, timeout_cnt[1], er);
    end
  endtask

  task automatic test_b_backpressure();
    mem_req_t gm, em;
    rsp_t gr, er;
    bit ok, unstable, mv;
    mem_exp_q.push_back({32'h0000_0008, 32'hAAAA_5555, 4'hF});
    rsp_exp_q.push_back({1'b1, 2'b00, 32'h0});
    send(1'b0, 1'b1, 1'b1, 1'b0, 32'h3000_0008, 32'hAAAA_5555, 4'hF, 32'h0);
    mem_serve(1'b0, 1, 32'h0, gm, ok);
    em = mem_exp_q.pop_front();
    vectors++;
    if ({ok, gm} !== {1'b1, em}) begin
      miscompares++;
      $display("FAIL bp_first_mem: got ok=%0b %h, expected %h", ok, gm, em);
    end
    for (int n = 0; n < 50 && !bvalid[0]; n++) @(negedge clk);
    mem_exp_q.push_back({32'h1200_0000, 32'h0BAD_F00D, 4'b1100});
    rsp_exp_q.push_back({1'b1, 2'b00, 32'h0});
    awaddr[0] = 32'h1200_0000; wdata[0] = 32'h0BAD_F00D; wstrb[0] = 4'b1100;
    awvalid[0] = 1'b1; wvalid[0] = 1'b1;
    unstable = 1'b0;
    mv = 1'b0;
    repeat (5) begin
      if ({bvalid[0], bresp[0]} !== 3'b100) unstable = 1'b1;
      @(negedge clk);
      awvalid[0] = 1'b0; wvalid[0] = 1'b0;
      if (mem_valid[0]) mv = 1'b1;
    end
    vectors++;
    if ({unstable, mv, awready[0], wready[0]} !== 4'b0000) begin
      miscompares++;
      $display("FAIL bp_hold: got unstable=%0b mem_valid=%0b awready=%0b wready=%0b, expected all 0",
               unstable, mv, awready[0], wready[0]);
    end
    gr = {1'b1, bresp[0], 32'h0};
    ok = bvalid[0];
    bready[0] = 1'b1;
    @(negedge clk);
    bready[0] = 1'b0;
    er = rsp_exp_q.pop_front();
    vectors++;
    if ({ok, gr} !== {1'b1, er}) begin
      miscompares++;
      $display("FAIL bp_first_rsp: got ok=%0b %h, expected %h", ok, gr, er);
    end
    mem_serve(1'b0, 0, 32'h0, gm, ok);
    em = mem_exp_q.pop_front();
    vectors++;
    if ({ok, gm} !== {1'b1, em}) begin
      miscompares++;
      $display("FAIL bp_second_mem: got ok=%0b %h, expected %h", ok, gm, em);
    end
    wait_rsp(1'b0, 0, gr, ok);
    er = rsp_exp_q.pop_front();
    vectors++;
    if ({ok, gr} !== {1'b1, er}) begin
      miscompares++;
      $display("FAIL bp_second_rsp: got ok=%0b %h, expected %h", ok, gr, er);
    end
  endtask

  task automatic test_reset_midflight();
    mem_req_t gm, em;
    rsp_t gr, er;
    bit ok, stray;
    send(1'b0, 1'b1, 1'b1, 1'b0, 32'h4000_0040, 32'h5555_AAAA, 4'hF, 32'h0);
    for (int n = 0; n < 50 && !mem_valid[0]; n++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({mem_valid[0], awready[0], timeout_cnt[1]} !== 10'h0) begin
      miscompares++;
      $display("FAIL async_reset: got mem_valid=%0b awready=%0b tcnt=%0d, expected 0 0 0",
               mem_valid[0], awready[0], timeout_cnt[1]);
    end
    @(negedge clk);
    rst = 1'b0;
    stray = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bvalid[0] || mem_valid[0]) stray = 1'b1;
    end
    vectors++;
    if (stray !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_quiet: got stray=%0b, expected 0", stray);
    end
    mem_exp_q.push_back({32'h1000_0100, 32'h0, 4'h0});
    rsp_exp_q.push_back({1'b0, 2'b00, 32'h5A5A_5A5A});
    send(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0, 32'h4000_0100);
    mem_serve(1'b0, 1, 32'h5A5A_5A5A, gm, ok);
    em = mem_exp_q.pop_front();
    vectors++;
    if ({ok, gm} !== {1'b1, em}) begin
      miscompares++;
      $display("FAIL post_reset_mem: got ok=%0b %h, expected %h", ok, gm, em);
    end
    wait_rsp(1'b0, 0, gr, ok);
    er = rsp_exp_q.pop_front();
    vectors++;
    if ({ok, gr} !== {1'b1, er}) begin
      miscompares++;
      $display("FAIL post_reset_rsp: got ok=%0b %h, expected %h", ok, gr, er);
    end
  endtask

  initial begin
    awaddr = '0; wdata = '0; araddr = '0; mem_rdata = '0; wstrb = '0;
    awvalid = '0; wvalid = '0; arvalid = '0; bready = '0; rready = '0; mem_ready = '0;
    test_reset();
    test_read_remap();
    test_write_w_first();
    test_arbitration(1'b0, 1'b0, 8'h21);
    test_arbitration(1'b1, 1'b0, 8'h32);
    test_arbitration(1'b1, 1'b1, 8'h43);
    test_timeout();
    test_b_backpressure();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
